bcd_countdown_timer: RTL and testbench
======================================

// Module: bcd_countdown_timer
//
// PURPOSE
// Parametrised N-digit BCD countdown timer: next-generation replacement for the fixed two-digit
// game timer. Loads a packed-BCD start value, decrements once per internal tick, supports
// pause/resume, bonus-time add with saturation and a low-time warning flag. Drives the 7-seg
// display path and signals the game FSM on expiry. One-second prescaler is built in.
//
// PARAMETERS
// NUM_DIGITS   2            number of BCD digits (1..8)
// TICK_CYCLES  50_000_000   clk cycles per countdown tick (>=2)
// WARN_VALUE   'h10         packed-BCD threshold; warning asserted while value <= WARN_VALUE
//
// PORTS
// clk          in   1             system clock
// rst          in   1             synchronous, active-high reset
// load         in   1             pulse: load load_value, restart prescaler
// load_value   in   4*NUM_DIGITS  packed BCD start value, digit 0 = LSBs
// enable       in   1             level: 1 = run, 0 = pause
// bonus_add    in   1             pulse: add bonus_value to current value
// bonus_value  in   4*NUM_DIGITS  packed BCD bonus amount
// digits       out  4*NUM_DIGITS  current value, packed BCD
// timeout      out  1             one-cycle pulse when value reaches 0 by counting
// expired      out  1             level, high in EXPIRED
// running      out  1             level, high in RUN
// warning      out  1             level, high when RUN/PAUSE and 0 < value <= WARN_VALUE
//
// BEHAVIOUR
// - Reset: digits=0, timeout=0, expired=0, running=0, warning=0, prescaler=0, state=IDLE.
// - FSM states IDLE, RUN, PAUSE, EXPIRED; all outputs registered.
// - load (any state): value<=clamped load_value (any digit >9 becomes 9); prescaler<=0.
//   Next state: clamped value==0 -> IDLE; else enable ? RUN : PAUSE. load has priority
//   over bonus_add and tick in the same cycle.
// - RUN: enable=0 -> PAUSE. PAUSE: enable=1 -> RUN. IDLE/EXPIRED ignore enable.
// - Prescaler counts 0..TICK_CYCLES-1 only in RUN; holds in PAUSE; tick = (count==TICK_CYCLES-1)
//   while in RUN, count wraps to 0. First tick after load+RUN occurs TICK_CYCLES cycles later.
// - On tick: BCD decrement with borrow ripple (x0 -> (x-1)9). If the result is 0: state<=EXPIRED,
//   timeout=1 for exactly the next cycle, digits show 0 that same cycle.
// - bonus_add in RUN/PAUSE: value<=value+bonus_value in BCD with carry ripple; result above
//   all-9s saturates to all-9s. Ignored in IDLE and EXPIRED. Bonus digits >9 clamped to 9.
// - Simultaneous tick and bonus_add: value<=sat(value+bonus)-1; expiry only if that result is 0.
// - EXPIRED: digits hold 0, expired=1, stays until load (or rst).
// - warning: combinational compare of packed BCD (unsigned compare valid for BCD), registered;
//   0 in IDLE/EXPIRED.
// - rst mid-count wins over every other input; no timeout pulse on reset.
//
// TESTING (TICK_CYCLES=4, NUM_DIGITS=2, WARN_VALUE='h10)
// 1. load 'h03, enable=1 -> digits 03,02,01,00 at 4-cycle spacing; timeout one cycle with 00; expired=1.
// 2. load 'h20, run to 'h10 -> warning rises with digits 'h10, 'h11 shows warning=0; borrow 20->19 correct.
// 3. load 'h05, enable=1, drop enable for 10 cycles after 2 ticks -> digits hold 03, prescaler resumes, no lost/extra tick.
// 4. value 'h95, bonus 'h07 -> digits 'h99 (saturate); value 'h45 bonus 'h08 -> 'h53; bonus in EXPIRED -> no change.
// 5. load 'hA7 -> digits 'h97; load 'h00 -> IDLE, no timeout; load+bonus same cycle -> load only.
// 6. rst asserted mid-count at 'h12 -> next cycle all outputs 0, IDLE, no timeout; tick+bonus 'h01 at value 'h01 -> 'h01, no expiry.

Source files
------------

// File: rtl/bcd_countdown_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bcd_countdown_timer                                        |
// | Description : N-digit packed-BCD countdown timer with built-in tick      |
// |               prescaler, pause/resume, saturating bonus-time add and a   |
// |               low-time warning flag.                                     |
// | Ports       : clk, rst          clock, synchronous active-high reset     |
// |               load/load_value   load a start value, restart prescaler    |
// |               enable            level, 1 = run, 0 = pause                |
// |               bonus_add/value   add bonus time while running or paused   |
// |               digits            current value, packed BCD                |
// |               timeout           one-cycle pulse on count-down expiry     |
// |               expired/running   state levels                             |
// |               warning           0 < value <= WARN_VALUE while RUN/PAUSE  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module bcd_countdown_timer #(
   parameter int          NUM_DIGITS  = 2,
   parameter int          TICK_CYCLES = 50_000_000,
   parameter logic [31:0] WARN_VALUE  = 32'h10
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] load_value,
   input  logic                    enable,
   input  logic                    bonus_add,
   input  logic [4*NUM_DIGITS-1:0] bonus_value,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic                    timeout,
   output logic                    expired,
   output logic                    running,
   output logic                    warning
);

   localparam int                     c_width   = 4 * NUM_DIGITS;
   localparam int                     c_cnt_w   = $clog2(TICK_CYCLES);
   localparam logic [c_cnt_w-1:0]     c_cnt_max = c_cnt_w'(TICK_CYCLES - 1);
   localparam logic [c_width-1:0]     c_all9    = {NUM_DIGITS{4'h9}};
   localparam logic [c_width-1:0]     c_warn    = WARN_VALUE[c_width-1:0];

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PAUSE   = 2'd2,
      ST_EXPIRED = 2'd3
   } state_t;

   // Any digit above 9 is forced to 9.
   function automatic logic [c_width-1:0] clamp_bcd(input logic [c_width-1:0] v);
      logic [c_width-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
      end
      return r;
   endfunction

   // Digit-serial BCD add; a carry out of the top digit saturates to all 9s.
   function automatic logic [c_width-1:0] add_bcd_sat(input logic [c_width-1:0] a,
                                                      input logic [c_width-1:0] b);
      logic [c_width-1:0] r;
      logic [4:0]         s;
      logic               c;
      r = '0;
      c = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c};
         if (s > 5'd9) begin
            s           = s - 5'd10;
            c           = 1'b1;
         end else begin
            c           = 1'b0;
         end
         r[4*i +: 4] = s[3:0];
      end
      return c ? c_all9 : r;
   endfunction

   // BCD decrement by one; a zero digit under borrow becomes 9 and passes the borrow on.
   function automatic logic [c_width-1:0] dec_bcd(input logic [c_width-1:0] v);
      logic [c_width-1:0] r;
      logic               b;
      r = v;
      b = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (b) begin
            if (v[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               b           = 1'b0;
            end
         end
      end
      return r;
   endfunction

   state_t               state_q,   state_d;
   logic [c_width-1:0]   value_q,   value_d;
   logic [c_cnt_w-1:0]   count_q,   count_d;
   logic                 timeout_q, timeout_d;
   logic                 expired_q, expired_d;
   logic                 running_q, running_d;
   logic                 warning_q, warning_d;

   logic                 w_tick;
   logic [c_width-1:0]   w_bonus_sum;
   logic [c_width-1:0]   w_run_base;
   logic [c_width-1:0]   w_run_value;

   assign w_tick      = (state_q == ST_RUN) && (count_q == c_cnt_max);
   assign w_bonus_sum = add_bcd_sat(value_q, clamp_bcd(bonus_value));
   // Bonus is applied before the decrement so a same-cycle tick yields sat(v+b)-1.
   assign w_run_base  = bonus_add ? w_bonus_sum : value_q;
   assign w_run_value = w_tick ? dec_bcd(w_run_base) : w_run_base;

   always_comb begin
      state_d   = state_q;
      value_d   = value_q;
      count_d   = count_q;
      timeout_d = 1'b0;

      if (load) begin
         value_d = clamp_bcd(load_value);
         count_d = '0;
         if (value_d == '0) begin
            state_d = ST_IDLE;
         end else begin
            state_d = enable ? ST_RUN : ST_PAUSE;
         end
      end else begin
         case (state_q)
            ST_RUN: begin
               count_d = w_tick ? '0 : count_q + 1'b1;
               value_d = w_run_value;
               if (w_run_value == '0) begin
                  state_d   = ST_EXPIRED;
                  timeout_d = 1'b1;
               end else if (!enable) begin
                  state_d = ST_PAUSE;
               end
            end
            ST_PAUSE: begin
               if (bonus_add) begin
                  value_d = w_bonus_sum;
               end
               if (enable) begin
                  state_d = ST_RUN;
               end
            end
            ST_EXPIRED: begin
               value_d = '0;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      running_d = (state_d == ST_RUN);
      expired_d = (state_d == ST_EXPIRED);
      // Packed BCD orders the same as its unsigned binary reading.
      warning_d = ((state_d == ST_RUN) || (state_d == ST_PAUSE)) &&
                  (value_d != '0) && (value_d <= c_warn);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         value_q   <= '0;
         count_q   <= '0;
         timeout_q <= 1'b0;
         expired_q <= 1'b0;
         running_q <= 1'b0;
         warning_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         value_q   <= value_d;
         count_q   <= count_d;
         timeout_q <= timeout_d;
         expired_q <= expired_d;
         running_q <= running_d;
         warning_q <= warning_d;
      end
   end

   assign digits  = value_q;
   assign timeout = timeout_q;
   assign expired = expired_q;
   assign running = running_q;
   assign warning = warning_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_countdown_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_bcd_countdown_timer                                     |
// | Description : Self-checking bench for bcd_countdown_timer (2 digits,     |
// |               4-cycle tick, warning at 'h10). Expected digit values and  |
// |               their cycle spacing are queued as stimulus is driven and   |
// |               popped by a monitor whenever the displayed value changes.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_bcd_countdown_timer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       load = 1'b0;
   logic [7:0] load_value = 8'h00;
   logic       enable = 1'b0;
   logic       bonus_add = 1'b0;
   logic [7:0] bonus_value = 8'h00;
   logic [7:0] digits;
   logic       timeout, expired, running, warning;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0] val;
      int         gap;   // expected cycles since previous change, 0 = unchecked
   } exp_t;

   exp_t       sb[$];
   logic       mon_on = 1'b0;
   logic [7:0] prev_digits = 8'h00;
   int         cyc_cnt = 0;
   int         last_cyc = 0;
   int         to_pulses = 0;

   bcd_countdown_timer #(
      .NUM_DIGITS (2),
      .TICK_CYCLES(4),
      .WARN_VALUE (32'h10)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .load_value (load_value),
      .enable     (enable),
      .bonus_add  (bonus_add),
      .bonus_value(bonus_value),
      .digits     (digits),
      .timeout    (timeout),
      .expired    (expired),
      .running    (running),
      .warning    (warning)
   );

   always #5 clk = ~clk;

   // Scoreboard monitor: every change of the displayed value must match the queue head.
   always @(posedge clk) begin
      exp_t e;
      #1;
      cyc_cnt++;
      if (mon_on) begin
         if (timeout === 1'b1) to_pulses++;
         if (digits !== prev_digits) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_change got=%h prev=%h", digits, prev_digits);
            end else begin
               e = sb.pop_front();
               if (digits !== e.val) begin
                  errors++;
                  $display("FAIL sb_digits got=%h want=%h", digits, e.val);
               end
               if (e.gap != 0) begin
                  checks++;
                  if (cyc_cnt - last_cyc != e.gap) begin
                     errors++;
                     $display("FAIL sb_spacing value=%h got=%0d want=%0d", e.val, cyc_cnt - last_cyc, e.gap);
                  end
               end
            end
            prev_digits = digits;
            last_cyc    = cyc_cnt;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   function automatic void push(input logic [7:0] v, input int gap);
      exp_t e;
      e.val = v;
      e.gap = gap;
      sb.push_back(e);
   endfunction

   task automatic drain(input string name);
      for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_drain got=%0d pending want=0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (digits  !== 8'h00) begin errors++; $display("FAIL rst_digits got=%h want=00", digits); end
      checks++; if (timeout !== 1'b0)  begin errors++; $display("FAIL rst_timeout got=%b want=0", timeout); end
      checks++; if (expired !== 1'b0)  begin errors++; $display("FAIL rst_expired got=%b want=0", expired); end
      checks++; if (running !== 1'b0)  begin errors++; $display("FAIL rst_running got=%b want=0", running); end
      checks++; if (warning !== 1'b0)  begin errors++; $display("FAIL rst_warning got=%b want=0", warning); end
      rst = 1'b0;
      @(negedge clk);
      prev_digits = 8'h00;
      mon_on      = 1'b1;
   endtask

   task automatic test_countdown();
      int early;
      early = 0;
      push(8'h03, 0); push(8'h02, 4); push(8'h01, 4); push(8'h00, 4);
      load = 1'b1; load_value = 8'h03; enable = 1'b1;
      @(negedge clk);
      load = 1'b0;
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL cd_running got=%b want=1", running); end
      checks++; if (warning !== 1'b1) begin errors++; $display("FAIL cd_warning got=%b want=1", warning); end
      for (int i = 0; i < 40 && sb.size() != 0; i++) begin
         @(negedge clk);
         if (sb.size() != 0 && timeout === 1'b1) early++;
      end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL cd_drain got=%0d pending want=0", sb.size()); sb.delete(); end
      checks++; if (early != 0)       begin errors++; $display("FAIL cd_early_timeout got=%0d want=0", early); end
      checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL cd_timeout got=%b want=1", timeout); end
      checks++; if (expired !== 1'b1) begin errors++; $display("FAIL cd_expired got=%b want=1", expired); end
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL cd_running_end got=%b want=0", running); end
      checks++; if (warning !== 1'b0) begin errors++; $display("FAIL cd_warning_end got=%b want=0", warning); end
      @(negedge clk);
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL cd_timeout_width got=%b want=0", timeout); end
      checks++; if (expired !== 1'b1) begin errors++; $display("FAIL cd_expired_hold got=%b want=1", expired); end
   endtask

   task automatic test_warning();
      logic c11;
      logic [7:0] v;
      c11 = 1'b0;
      push(8'h20, 0);
      v = 8'h19;
      for (int i = 0; i < 10; i++) begin
         push(v, 4);
         v = (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : v - 8'd1;
      end
      load = 1'b1; load_value = 8'h20; enable = 1'b1;
      @(negedge clk);
      load = 1'b0;
      checks++; if (warning !== 1'b0) begin errors++; $display("FAIL warn_at20 got=%b want=0", warning); end
      for (int i = 0; i < 80 && sb.size() != 0; i++) begin
         @(negedge clk);
         if (sb.size() == 1 && !c11) begin
            c11 = 1'b1;
            checks++;
            if (warning !== 1'b0) begin errors++; $display("FAIL warn_at11 got=%b want=0", warning); end
         end
      end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL warn_drain got=%0d pending want=0", sb.size()); sb.delete(); end
      checks++; if (!c11)              begin errors++; $display("FAIL warn_seen11 got=0 want=1"); end
      checks++; if (warning !== 1'b1)  begin errors++; $display("FAIL warn_at10 got=%b want=1", warning); end
   endtask

   task automatic test_pause();
      push(8'h05, 0); push(8'h04, 4); push(8'h03, 4);
      load = 1'b1; load_value = 8'h05; enable = 1'b1;
      @(negedge clk);
      load = 1'b0;
      drain("pause_pre");
      // One RUN edge with enable low, nine PAUSE edges, then the resume edge in PAUSE.
      enable = 1'b0;
      push(8'h02, 14); push(8'h01, 4); push(8'h00, 4);
      @(negedge clk);
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL pause_running got=%b want=0", running); end
      checks++; if (warning !== 1'b1) begin errors++; $display("FAIL pause_warning got=%b want=1", warning); end
      repeat (9) @(negedge clk);
      checks++; if (digits !== 8'h03) begin errors++; $display("FAIL pause_hold got=%h want=03", digits); end
      enable = 1'b1;
      drain("pause_post");
      checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL pause_timeout got=%b want=1", timeout); end
      @(negedge clk);
   endtask

   task automatic test_bonus();
      enable = 1'b0;
      push(8'h95, 0);
      load = 1'b1; load_value = 8'h95;
      @(negedge clk);
      load = 1'b0;
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL bonus_paused got=%b want=0", running); end
      push(8'h99, 0);
      bonus_add = 1'b1; bonus_value = 8'h07;
      @(negedge clk);
      bonus_add = 1'b0;
      push(8'h45, 0);
      load = 1'b1; load_value = 8'h45;
      @(negedge clk);
      load = 1'b0;
      push(8'h53, 0);
      bonus_add = 1'b1; bonus_value = 8'h08;
      @(negedge clk);
      push(8'h72, 0);
      bonus_value = 8'h1F;
      @(negedge clk);
      bonus_add = 1'b0;
      checks++; if (digits !== 8'h72) begin errors++; $display("FAIL bonus_clamp got=%h want=72", digits); end
      enable = 1'b1;
      push(8'h01, 0); push(8'h00, 4);
      load = 1'b1; load_value = 8'h01;
      @(negedge clk);
      load = 1'b0;
      drain("bonus_exp");
      @(negedge clk);
      bonus_add = 1'b1; bonus_value = 8'h05;
      @(negedge clk);
      bonus_add = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (digits !== 8'h00)  begin errors++; $display("FAIL bonus_expired_digits got=%h want=00", digits); end
      checks++; if (expired !== 1'b1)  begin errors++; $display("FAIL bonus_expired_state got=%b want=1", expired); end
   endtask

   task automatic test_load();
      enable = 1'b0;
      push(8'h97, 0);
      load = 1'b1; load_value = 8'hA7;
      @(negedge clk);
      load = 1'b0;
      checks++; if (expired !== 1'b0) begin errors++; $display("FAIL load_clamp_expired got=%b want=0", expired); end
      push(8'h00, 0);
      load = 1'b1; load_value = 8'h00;
      @(negedge clk);
      load = 1'b0;
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL load_zero_timeout got=%b want=0", timeout); end
      checks++; if (expired !== 1'b0) begin errors++; $display("FAIL load_zero_expired got=%b want=0", expired); end
      enable = 1'b1;
      repeat (6) @(negedge clk);
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL idle_ignores_enable got=%b want=0", running); end
      enable = 1'b0;
      push(8'h30, 0);
      load = 1'b1; load_value = 8'h30; bonus_add = 1'b1; bonus_value = 8'h05;
      @(negedge clk);
      load = 1'b0; bonus_add = 1'b0;
      checks++; if (digits !== 8'h30) begin errors++; $display("FAIL load_over_bonus got=%h want=30", digits); end
   endtask

   task automatic test_reset_mid();
      enable = 1'b1;
      push(8'h14, 0); push(8'h13, 4); push(8'h12, 4);
      load = 1'b1; load_value = 8'h14;
      @(negedge clk);
      load = 1'b0;
      drain("rstmid_pre");
      repeat (2) @(negedge clk);
      push(8'h00, 0);
      rst = 1'b1; load = 1'b1; load_value = 8'h55;
      @(negedge clk);
      checks++; if (digits  !== 8'h00) begin errors++; $display("FAIL rstmid_digits got=%h want=00", digits); end
      checks++; if (timeout !== 1'b0)  begin errors++; $display("FAIL rstmid_timeout got=%b want=0", timeout); end
      checks++; if (expired !== 1'b0)  begin errors++; $display("FAIL rstmid_expired got=%b want=0", expired); end
      checks++; if (running !== 1'b0)  begin errors++; $display("FAIL rstmid_running got=%b want=0", running); end
      checks++; if (warning !== 1'b0)  begin errors++; $display("FAIL rstmid_warning got=%b want=0", warning); end
      rst = 1'b0; load = 1'b0;
      @(negedge clk);
      checks++; if (running !== 1'b0)  begin errors++; $display("FAIL rstmid_idle got=%b want=0", running); end
      // Tick and bonus 01 coincide at value 01: sat(01+01)-1 = 01, no expiry.
      push(8'h01, 0);
      load = 1'b1; load_value = 8'h01;
      @(negedge clk);
      load = 1'b0;
      checks++; if (warning !== 1'b1) begin errors++; $display("FAIL tb_warning got=%b want=1", warning); end
      repeat (3) @(negedge clk);
      bonus_add = 1'b1; bonus_value = 8'h01;
      @(negedge clk);
      bonus_add = 1'b0;
      checks++; if (digits  !== 8'h01) begin errors++; $display("FAIL tickbonus_digits got=%h want=01", digits); end
      checks++; if (expired !== 1'b0)  begin errors++; $display("FAIL tickbonus_expired got=%b want=0", expired); end
      checks++; if (running !== 1'b1)  begin errors++; $display("FAIL tickbonus_running got=%b want=1", running); end
      push(8'h00, 8);
      drain("tickbonus");
      checks++; if (timeout !== 1'b1)  begin errors++; $display("FAIL tickbonus_timeout got=%b want=1", timeout); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_countdown();
      test_warning();
      test_pause();
      test_bonus();
      test_load();
      test_reset_mid();
      repeat (2) @(negedge clk);
      checks++; if (to_pulses != 4) begin errors++; $display("FAIL timeout_pulse_count got=%0d want=4", to_pulses); end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got=%0d want=0", sb.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
